fb_draw_sink: RTL and testbench



---
 rtl/fb_draw_sink.sv | 223 ++++++++++++++++++++++
 tb/tb_fb_draw_sink.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_draw_sink.sv
// Draw-stream sink: captures pixel writes into a 160x120x9 framebuffer, clears it on reset/request,
// and scans it out as 640x480@60 VGA with each framebuffer pixel drawn as a 4x4 block.
module fb_draw_sink #(
  parameter int                       FB_WIDTH      = 160,
  parameter int                       FB_HEIGHT     = 120,
  parameter int                       FB_COLOR_BITS = 9,
  parameter logic [FB_COLOR_BITS-1:0] CLEAR_COLOR   = '0,
  parameter int                       CLK_DIV       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Draw_X,
  input  logic [31:0] Draw_Y,
  input  logic [31:0] Draw_Color,
  input  logic        Enable_Draw,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        frame_start,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);

  localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = $clog2(FB_WIDTH);
  localparam int YW    = $clog2(FB_HEIGHT);
  localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [31:0]   FB_W32    = 32'(FB_WIDTH);
  localparam logic [31:0]   FB_H32    = 32'(FB_HEIGHT);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] HS_START = 10'd656;
  localparam logic [9:0] HS_END   = 10'd752;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] VS_START = 10'd490;
  localparam logic [9:0] VS_END   = 10'd492;

  typedef enum logic {S_IDLE, S_CLEAR} clr_state_e;

  clr_state_e              state_q, state_d;
  logic [AW-1:0]           clr_addr_q, clr_addr_d;

  logic                    wr_vld_q, wr_vld_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [FB_COLOR_BITS-1:0] wr_col_q, wr_col_d;

  logic [PW-1:0]           phase_q, phase_d;
  logic [9:0]              hc_q, hc_d;
  logic [9:0]              vc_q, vc_d;
  logic                    frame_start_q, frame_start_d;

  logic                    s1_vis_q, s1_vis_d;
  logic                    s1_hs_q, s1_hs_d;
  logic                    s1_vs_q, s1_vs_d;

  logic [7:0]              vga_r_q, vga_r_d;
  logic [7:0]              vga_g_q, vga_g_d;
  logic [7:0]              vga_b_q, vga_b_d;
  logic                    vga_hs_q, vga_hs_d;
  logic                    vga_vs_q, vga_vs_d;
  logic                    vga_blank_n_q, vga_blank_n_d;

  logic                    tick;
  logic                    draw_in_range;
  logic [AW-1:0]           draw_addr;
  logic [AW-1:0]           rd_addr;
  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic [FB_COLOR_BITS-1:0] ram_wdat;
  logic [FB_COLOR_BITS-1:0] ram_rd_dat;
  logic [FB_COLOR_BITS-1:0] mem [DEPTH];
  logic                    color_hi_unused;

  assign color_hi_unused = ^Draw_Color[31:FB_COLOR_BITS];
  assign clear_busy      = (state_q == S_CLEAR);

  // Clear engine: a request always restarts the sweep from address 0.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      S_CLEAR: begin
        if (clear_req) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  // Full-width compares so wrapped negative coordinates are rejected.
  always_comb begin
    draw_in_range = (Draw_X < FB_W32) && (Draw_Y < FB_H32);
    draw_addr     = AW'(Draw_Y[YW-1:0]) * AW'(FB_WIDTH) + AW'(Draw_X[XW-1:0]);
    wr_vld_d      = Enable_Draw && draw_in_range && !clear_busy;
    wr_addr_d     = draw_addr;
    wr_col_d      = Draw_Color[FB_COLOR_BITS-1:0];
  end

  // The clear sweep owns the write port; a captured draw colliding with it is lost.
  always_comb begin
    ram_we    = clear_busy || wr_vld_q;
    ram_waddr = clear_busy ? clr_addr_q : wr_addr_q;
    ram_wdat  = clear_busy ? CLEAR_COLOR : wr_col_q;
  end

  always_comb begin
    tick    = (phase_q == PW'(CLK_DIV - 1));
    phase_d = tick ? '0 : phase_q + PW'(1);
    hc_d    = hc_q;
    vc_d    = vc_q;
    if (tick) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
    frame_start_d = tick && (hc_q == 10'd0) && (vc_q == 10'd0);

    s1_vis_d = (hc_q < H_VIS) && (vc_q < V_VIS);
    s1_hs_d  = !((hc_q >= HS_START) && (hc_q < HS_END));
    s1_vs_d  = !((vc_q >= VS_START) && (vc_q < VS_END));
    rd_addr  = s1_vis_d ? (AW'(vc_q[9:2]) * AW'(FB_WIDTH) + AW'(hc_q[9:2])) : '0;
  end

  // 3-bit channels widen by bit replication so full scale maps to 8'hFF.
  always_comb begin
    vga_r_d       = '0;
    vga_g_d       = '0;
    vga_b_d       = '0;
    if (s1_vis_q) begin
      vga_r_d = {ram_rd_dat[8:6], ram_rd_dat[8:6], ram_rd_dat[8:7]};
      vga_g_d = {ram_rd_dat[5:3], ram_rd_dat[5:3], ram_rd_dat[5:4]};
      vga_b_d = {ram_rd_dat[2:0], ram_rd_dat[2:0], ram_rd_dat[2:1]};
    end
    vga_hs_d      = s1_hs_q;
    vga_vs_d      = s1_vs_q;
    vga_blank_n_d = s1_vis_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_CLEAR;
      clr_addr_q    <= '0;
      wr_vld_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_col_q      <= '0;
      phase_q       <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      frame_start_q <= 1'b0;
      s1_vis_q      <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_blank_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      wr_vld_q      <= wr_vld_d;
      wr_addr_q     <= wr_addr_d;
      wr_col_q      <= wr_col_d;
      phase_q       <= phase_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_start_q <= frame_start_d;
      s1_vis_q      <= s1_vis_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_blank_n_q <= vga_blank_n_d;
    end
  end

  // Simple dual-port RAM, read-before-write, no reset on contents.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdat;
    end
    ram_rd_dat <= mem[rd_addr];
  end

  assign frame_start = frame_start_q;
  assign VGA_R       = vga_r_q;
  assign VGA_G       = vga_g_q;
  assign VGA_B       = vga_b_q;
  assign VGA_HS      = vga_hs_q;
  assign VGA_VS      = vga_vs_q;
  assign VGA_BLANK_N = vga_blank_n_q;

endmodule

// File: tb/tb_fb_draw_sink.sv
// Bench for fb_draw_sink: reset/clear timing, scanout pixels against a framebuffer model, sync timing.
module tb_fb_draw_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] draw_x, draw_y, draw_color;
  logic        enable_draw, clear_req;
  logic        clear_busy, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n;

  fb_draw_sink dut (
    .clk         (clk),
    .reset       (reset),
    .Draw_X      (draw_x),
    .Draw_Y      (draw_y),
    .Draw_Color  (draw_color),
    .Enable_Draw (enable_draw),
    .clear_req   (clear_req),
    .clear_busy  (clear_busy),
    .frame_start (frame_start),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_blank_n)
  );

  always #10 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int rst_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         addr;
    logic [8:0] col;
    int         issue;
  } wr_t;

  wr_t        pend[$];
  logic [8:0] mm [19200];

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int busy_low;
    int fs_cnt;
    int fs_rel;
    logic [29:0] obs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    obs = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, clear_busy};
    total++;
    if (obs !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_values got=%h exp=%h", obs, {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    else passed++;

    reset = 1'b0;
    rst_cyc = cyc;
    busy_low = 0;
    fs_cnt = 0;
    fs_rel = -1;
    for (int k = 0; k < 10000; k++) begin
      if (!clear_busy) busy_low++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_rel < 0) fs_rel = cyc - rst_cyc;
      end
      @(negedge clk);
    end
    total++;
    if (busy_low != 0) $display("FAIL busy_first_10000 low_cycles=%0d exp=0", busy_low);
    else passed++;
    total++;
    if (fs_cnt != 1 || fs_rel < 0 || fs_rel > 3)
      $display("FAIL frame_start_after_reset pulses=%0d at_rel=%0d exp=1 pulse within rel 0..3", fs_cnt, fs_rel);
    else passed++;

    // reset again while the sweep is around address 10000
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (clear_busy !== 1'b1) $display("FAIL busy_during_reset got=%b exp=1", clear_busy);
    else passed++;
    reset = 1'b0;
    rst_cyc = cyc;
  endtask

  task automatic test_clear_duration();
    int busy_cnt = 0;
    int rel;
    bit done = 0;
    for (int k = 0; k < 25000 && !done; k++) begin
      rel = cyc - rst_cyc;
      enable_draw = 1'b0;
      draw_color  = 32'h000001FF;
      if (clear_busy) busy_cnt++;
      else done = 1;
      if (done) begin
        draw_x = 32'd5; draw_y = 32'd3; draw_color = 32'h000001C0; enable_draw = 1'b1;
        pend.push_back('{3 * 160 + 5, 9'h1C0, cyc});
      end else if (rel == 100 || rel == 19199) begin
        draw_x = 32'd0;   draw_y = 32'd0; enable_draw = 1'b1;
      end else if (rel == 101 || rel == 19198) begin
        draw_x = 32'd7;   draw_y = 32'd4; enable_draw = 1'b1;
      end else if (rel == 102 || rel == 19197) begin
        draw_x = 32'd100; draw_y = 32'd3; enable_draw = 1'b1;
      end else if (rel == 103 || rel == 19196) begin
        draw_x = 32'd150; draw_y = 32'd5; enable_draw = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    total++;
    if (!done || busy_cnt != 19200)
      $display("FAIL clear_after_reset busy_cycles=%0d exp=19200 (fell=%0d)", busy_cnt, done);
    else passed++;
  endtask

  task automatic test_scan(input int ncyc);
    logic [31:0] sx [7];
    logic [31:0] sy [7];
    logic [31:0] x, y;
    logic [27:0] obs, expv;
    logic [8:0]  col;
    int c, r, rel, pix, hc, vc, cr, cg, cb;
    bit vis;
    sx[0] = 32'd7;          sy[0] = 32'd4;
    sx[1] = 32'd100;        sy[1] = 32'd3;
    sx[2] = 32'd150;        sy[2] = 32'd5;
    sx[3] = 32'd160;        sy[3] = 32'd4;
    sx[4] = 32'd0;          sy[4] = 32'd120;
    sx[5] = 32'hFFFFFFFF;   sy[5] = 32'd4;
    sx[6] = 32'd5;          sy[6] = 32'hFFFFFFFC;
    for (int a = 0; a < 19200; a++) mm[a] = 9'h000;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      c = cyc;
      r = c - 2;
      while (pend.size() > 0 && pend[0].issue <= r - 2) begin
        mm[pend[0].addr] = pend[0].col;
        void'(pend.pop_front());
      end
      rel = r - rst_cyc;
      pix = rel / 2;
      hc  = pix % 800;
      vc  = (pix / 800) % 525;
      vis = (hc < 640) && (vc < 480);
      col = vis ? mm[(vc / 4) * 160 + hc / 4] : 9'h000;
      cr = col[8:6]; cg = col[5:3]; cb = col[2:0];
      expv = {8'(cr * 36 + cr / 2), 8'(cg * 36 + cg / 2), 8'(cb * 36 + cb / 2),
              1'(!(hc >= 656 && hc < 752)), 1'(!(vc >= 490 && vc < 492)), 1'(vis), 1'b0};
      obs = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, clear_busy};
      total++;
      if (obs !== expv)
        $display("FAIL scan_pixel rel=%0d hc=%0d vc=%0d got=%h exp=%h", c - rst_cyc, hc, vc, obs, expv);
      else passed++;

      enable_draw = 1'b0;
      x = 32'd0; y = 32'd0;
      draw_color = $urandom;
      if (i < 7) begin
        x = sx[i]; y = sy[i]; draw_color = 32'hABC001FF; enable_draw = 1'b1;
      end else if ($urandom_range(0, 5) == 0) begin
        enable_draw = 1'b1;
        rel = c + 1 - rst_cyc;
        pix = rel / 2;
        hc  = pix % 800;
        vc  = (pix / 800) % 525;
        case ($urandom_range(0, 9))
          0: begin x = 32'd160 + $urandom_range(0, 1000); y = $urandom_range(0, 119); end
          1: begin x = $urandom_range(0, 159); y = 32'hFFFFFFFF - $urandom_range(0, 8); end
          2, 3: begin
            // hit the address the scanout reads in the same clk as this write lands
            if (hc < 640 && vc < 480) begin x = hc / 4; y = vc / 4; end
            else begin x = $urandom_range(0, 159); y = (vc / 4 > 119) ? 119 : vc / 4; end
          end
          default: begin
            x = $urandom_range(0, 159);
            y = vc / 4 + $urandom_range(0, 3);
            if (y > 119) y = 119;
          end
        endcase
      end
      draw_x = x;
      draw_y = y;
      if (enable_draw && x < 32'd160 && y < 32'd120)
        pend.push_back('{int'(y) * 160 + int'(x), draw_color[8:0], c});
    end
    @(negedge clk);
    enable_draw = 1'b0;
  endtask

  task automatic test_hsync();
    logic prev;
    bit found, risen;
    int low, blank_hi, vs_lo;
    for (int ln = 0; ln < 2; ln++) begin
      found = 0;
      prev = vga_hs;
      for (int k = 0; k < 2000 && !found; k++) begin
        @(negedge clk);
        if (prev === 1'b1 && vga_hs === 1'b0) found = 1;
        prev = vga_hs;
      end
      total++;
      if (!found || ((cyc - rst_cyc) % 1600) != 1314)
        $display("FAIL hs_fall_pos found=%0d rel_mod_line=%0d exp=1314", found, (cyc - rst_cyc) % 1600);
      else passed++;
      low = 1;
      risen = 0;
      for (int k = 0; k < 400 && !risen; k++) begin
        @(negedge clk);
        if (vga_hs === 1'b1) risen = 1;
        else low++;
      end
      total++;
      if (!risen || low != 192) $display("FAIL hs_low_width got=%0d exp=192", low);
      else passed++;
    end
    blank_hi = 0;
    vs_lo = 0;
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk);
      if (vga_blank_n === 1'b1) blank_hi++;
      if (vga_vs !== 1'b1) vs_lo++;
    end
    total++;
    if (blank_hi != 1280) $display("FAIL blank_n_per_line got=%0d exp=1280", blank_hi);
    else passed++;
    total++;
    if (vs_lo != 0) $display("FAIL vs_in_active_lines low_cycles=%0d exp=0", vs_lo);
    else passed++;
  endtask

  task automatic test_clear_req();
    int busy_low, busy_cnt;
    bit fell = 0;
    @(negedge clk);
    total++;
    if (clear_busy !== 1'b0) $display("FAIL idle_before_req got=%b exp=0", clear_busy);
    else passed++;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    total++;
    if (clear_busy !== 1'b1) $display("FAIL busy_after_req got=%b exp=1", clear_busy);
    else passed++;
    busy_low = 0;
    for (int k = 0; k < 2999; k++) begin
      @(negedge clk);
      if (clear_busy !== 1'b1) busy_low++;
    end
    total++;
    if (busy_low != 0) $display("FAIL busy_mid_clear low_cycles=%0d exp=0", busy_low);
    else passed++;
    // restart mid-sweep: busy must last 19200 clks counted from the request
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 25000 && !fell; k++) begin
      if (clear_busy === 1'b1) begin
        busy_cnt++;
        @(negedge clk);
      end else fell = 1;
    end
    total++;
    if (!fell || busy_cnt != 19200)
      $display("FAIL restart_clear busy_cycles=%0d exp=19200 (fell=%0d)", busy_cnt, fell);
    else passed++;
  endtask

  initial begin
    reset       = 1'b1;
    draw_x      = '0;
    draw_y      = '0;
    draw_color  = '0;
    enable_draw = 1'b0;
    clear_req   = 1'b0;
    test_reset();
    test_clear_duration();
    test_scan(16000);
    test_hsync();
    test_clear_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
